// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN pipeline stages.
// Holds the element width, pooling FSM state encoding and pooled-dimension helper.
package cnn_pkg;

    localparam int unsigned DATA_W = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POOL = 2'd1,
        DONE = 2'd2
    } state_t;

    // 2x2 stride-2 pooling drops a trailing odd row/column.
    function automatic int unsigned pooled_dim(input int unsigned n);
        return n / 2;
    endfunction

endpackage

// File: rtl/pool_max4.sv
// Combinational signed maximum of four operands.
// The result is one of the inputs unchanged; ties may return any equal operand.
module pool_max4 #(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] max_o
);

    logic [DATA_W-1:0] max_ab;
    logic [DATA_W-1:0] max_cd;

    always_comb begin
        max_ab = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
        max_cd = ($signed(c_i) > $signed(d_i)) ? c_i : d_i;
        max_o  = ($signed(max_ab) > $signed(max_cd)) ? max_ab : max_cd;
    end

endmodule

// File: rtl/maxpool_unit.sv
// 2x2 stride-2 max-pooling stage: one pooled pixel (all channels) per cycle
// under a start/done handshake; the pooled map is held in output registers.
module maxpool_unit #(
    parameter int unsigned WIDTH    = 28,
    parameter int unsigned HEIGHT   = 28,
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned DATA_W   = cnn_pkg::DATA_W,
    localparam int unsigned OH      = cnn_pkg::pooled_dim(HEIGHT),
    localparam int unsigned OW      = cnn_pkg::pooled_dim(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] fmap_in  [HEIGHT][WIDTH][CHANNELS],
    output logic [DATA_W-1:0] fmap_out [OH][OW][CHANNELS],
    output logic              busy,
    output logic              done
);

    import cnn_pkg::*;

    localparam int unsigned RW  = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned CW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned HIW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned WIW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic              pool_en;

    logic [DATA_W-1:0] fmap_q [OH][OW][CHANNELS];
    logic [DATA_W-1:0] max_w  [CHANNELS];

    logic [HIW-1:0]    row0, row1;
    logic [WIW-1:0]    col0, col1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        pool_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = POOL;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            POOL: begin
                pool_en = 1'b1;
                if (c_q == CW'(OW - 1)) begin
                    c_d = '0;
                    if (r_q == RW'(OH - 1)) begin
                        state_d = DONE;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Top-left corner of the current 2x2 window in input coordinates.
    always_comb begin
        row0 = HIW'(2 * r_q);
        row1 = HIW'(2 * r_q + 1);
        col0 = WIW'(2 * c_q);
        col1 = WIW'(2 * c_q + 1);
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pool_max4 #(
            .DATA_W (DATA_W)
        ) u_max (
            .a_i   (fmap_in[row0][col0][k]),
            .b_i   (fmap_in[row0][col1][k]),
            .c_i   (fmap_in[row1][col0][k]),
            .d_i   (fmap_in[row1][col1][k]),
            .max_o (max_w[k])
        );
    end

    // Pixels outside the current write keep their previous-pass value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OH; i++) begin
                for (int j = 0; j < OW; j++) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        fmap_q[i][j][k] <= '0;
                    end
                end
            end
        end else if (pool_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                fmap_q[r_q][c_q][k] <= max_w[k];
            end
        end
    end

    assign fmap_out = fmap_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_maxpool_unit.sv
// Scoreboard bench for maxpool_unit: stimulus pushes expected done cycles and maps,
// a negedge monitor pops and compares whenever done is presented.
module tb_maxpool_unit;

    localparam int W = 28, H = 28, C = 16, OH = 14, OW = 14;
    localparam int SW = 7, SH = 5, SC = 2, SOH = 2, SOW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_b = 1'b0;
    logic start_s = 1'b0;
    logic busy_b, done_b, busy_s, done_s;

    logic [17:0] fin_b  [H][W][C];
    logic [17:0] fout_b [OH][OW][C];
    logic [17:0] exp_b  [OH][OW][C];
    logic [17:0] fin_s  [SH][SW][SC];
    logic [17:0] fout_s [SOH][SOW][SC];
    logic [17:0] exp_s  [SOH][SOW][SC];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int q_b[$];
    int q_s[$];
    int exp_cyc_b, exp_cyc_s;
    int k0, low, lowat;

    maxpool_unit u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .fmap_in  (fin_b),
        .fmap_out (fout_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    maxpool_unit #(
        .WIDTH    (SW),
        .HEIGHT   (SH),
        .CHANNELS (SC),
        .DATA_W   (18)
    ) u_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s),
        .fmap_in  (fin_s),
        .fmap_out (fout_s),
        .busy     (busy_s),
        .done     (done_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cmp_map_b(input string name);
        int bad, fr, fc, fk;
        bad = 0; fr = 0; fc = 0; fk = 0;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                for (int k = 0; k < C; k++)
                    if (fout_b[r][c][k] !== exp_b[r][c][k]) begin
                        if (bad == 0) begin fr = r; fc = c; fk = k; end
                        bad++;
                    end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d wrong elements, first [%0d][%0d][%0d] got %h expected %h",
                     name, bad, fr, fc, fk, fout_b[fr][fc][fk], exp_b[fr][fc][fk]);
        end
    endtask

    task automatic cmp_map_s(input string name);
        int bad, fr, fc, fk;
        bad = 0; fr = 0; fc = 0; fk = 0;
        for (int r = 0; r < SOH; r++)
            for (int c = 0; c < SOW; c++)
                for (int k = 0; k < SC; k++)
                    if (fout_s[r][c][k] !== exp_s[r][c][k]) begin
                        if (bad == 0) begin fr = r; fc = c; fk = k; end
                        bad++;
                    end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d wrong elements, first [%0d][%0d][%0d] got %h expected %h",
                     name, bad, fr, fc, fk, fout_s[fr][fc][fk], exp_s[fr][fc][fk]);
        end
    endtask

    task automatic clear_b();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < C; k++) fin_b[r][c][k] = '0;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                for (int k = 0; k < C; k++) exp_b[r][c][k] = '0;
    endtask

    // Window max placed at a rotating corner; losers are base-1, base-2, base-3.
    task automatic fill_pattern_b(input int seed);
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                for (int k = 0; k < C; k++) begin
                    int win, base, n, v;
                    win  = (r + c + k + seed) % 4;
                    base = (r * OW + c) * 4 + k - 300 + seed * 7;
                    n    = 1;
                    for (int q = 0; q < 4; q++) begin
                        if (q == win) v = base;
                        else begin v = base - n; n++; end
                        fin_b[2*r + q/2][2*c + q%2][k] = 18'(v);
                    end
                    exp_b[r][c][k] = 18'(base);
                end
    endtask

    task automatic fill_pattern_s();
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                for (int k = 0; k < SC; k++) fin_s[r][c][k] = 18'h1FFFF;
        for (int r = 0; r < SOH; r++)
            for (int c = 0; c < SOW; c++)
                for (int k = 0; k < SC; k++) begin
                    int win, base, n, v;
                    win  = (r + 2 * c + k) % 4;
                    base = (r * SOW + c) * 4 + k - 9;
                    n    = 1;
                    for (int q = 0; q < 4; q++) begin
                        if (q == win) v = base;
                        else begin v = base - n; n++; end
                        fin_s[2*r + q/2][2*c + q%2][k] = 18'(v);
                    end
                    exp_s[r][c][k] = 18'(base);
                end
    endtask

    task automatic start_pass_b();
        @(negedge clk);
        start_b = 1'b1;
        q_b.push_back(cyc + 197);
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic start_pass_s();
        @(negedge clk);
        start_s = 1'b1;
        q_s.push_back(cyc + 7);
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q_b.size() + q_s.size()) > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_done", q_b.size() + q_s.size(), 0);
        q_b.delete();
        q_s.delete();
    endtask

    always @(negedge clk) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_b_unexpected: done at cycle %0d, expected no done", cyc);
            end else begin
                exp_cyc_b = q_b.pop_front();
                check("done_b_cycle", cyc, exp_cyc_b);
                cmp_map_b("map_b");
            end
        end
    end

    always @(negedge clk) begin
        if (done_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_s_unexpected: done at cycle %0d, expected no done", cyc);
            end else begin
                exp_cyc_s = q_s.pop_front();
                check("done_s_cycle", cyc, exp_cyc_s);
                cmp_map_s("map_s");
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_b();
        fill_pattern_s();
        repeat (3) @(negedge clk);
        check("busy_in_reset", busy_b, 0);
        check("done_in_reset", done_b, 0);
        cmp_map_b("map_in_reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Rotating-corner window pattern.
        fill_pattern_b(0);
        start_pass_b();
        check("busy_during_pass", busy_b, 1);
        wait_drain(400);

        // Single hot element in the bottom-right corner.
        clear_b();
        fin_b[27][27][15] = 18'h1FFFF;
        exp_b[13][13][15] = 18'h1FFFF;
        start_pass_b();
        wait_drain(400);
        check("hot_elem", fout_b[13][13][15], 'h1FFFF);
        check("hot_neighbour", fout_b[13][13][14], 0);

        // Signed windows.
        clear_b();
        for (int k = 0; k < C; k++) begin
            fin_b[0][0][k] = 18'h3FFFF;
            fin_b[0][1][k] = 18'h20000;
            fin_b[1][0][k] = 18'd5;
            fin_b[1][1][k] = 18'd0;
            exp_b[0][0][k] = 18'd5;
            fin_b[0][2][k] = 18'h3FFFF;
            fin_b[0][3][k] = 18'h3FFFE;
            fin_b[1][2][k] = 18'h3FFFD;
            fin_b[1][3][k] = 18'h3FFFC;
            exp_b[0][1][k] = 18'h3FFFF;
        end
        start_pass_b();
        wait_drain(400);
        check("signed_mixed", fout_b[0][0][7], 5);
        check("signed_all_neg", fout_b[0][1][7], 'h3FFFF);

        // start held high across two passes.
        fill_pattern_b(1);
        @(negedge clk);
        k0 = cyc;
        start_b = 1'b1;
        q_b.push_back(k0 + 197);
        q_b.push_back(k0 + 395);
        low = 0;
        lowat = -1;
        for (int i = 1; i <= 395; i++) begin
            @(negedge clk);
            if (cyc == k0 + 199) start_b = 1'b0;
            if (!busy_b) begin
                low++;
                lowat = cyc;
            end
        end
        check("busy_low_cycles", low, 1);
        check("busy_low_at", lowat - k0, 198);
        wait_drain(50);

        // Reset at edge 100 of a pass.
        fill_pattern_b(2);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("busy_before_abort", busy_b, 1);
        rst_n = 1'b0;
        #1;
        check("busy_after_abort", busy_b, 0);
        check("done_after_abort", done_b, 0);
        clear_b();
        cmp_map_b("map_after_abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);
        check("busy_idle_after_abort", busy_b, 0);

        fill_pattern_b(3);
        start_pass_b();
        wait_drain(400);

        // 5x7 instance: 2x3 outputs.
        start_pass_s();
        wait_drain(50);
        check("small_elem", fout_s[1][2][1], exp_s[1][2][1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_unit.md
# maxpool_unit

2x2 stride-2 max-pooling stage placed directly downstream of the L2 ReLU stage. It consumes the rectified L2 feature map, a 28x28x16 array of 18-bit values. It produces a 14x14x16 pooled map, one output pixel (all channels in parallel) per cycle, under a start/done handshake. The pooled map feeds the flatten/dense stage.

## Interface
- WIDTH, 28, input map width (columns)
- HEIGHT, 28, input map height (rows)
- CHANNELS, 16, channel count
- DATA_W, 18, element width, two's complement
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pooling pass; sampled only in IDLE
- fmap_in  in  DATA_W x [HEIGHT][WIDTH][CHANNELS]  rectified L2 map; held stable by upstream from start acceptance until done
- fmap_out  out  DATA_W x [HEIGHT/2][WIDTH/2][CHANNELS]  pooled map
- busy  out  1  high in POOL and DONE
- done  out  1  one-cycle pulse when fmap_out is complete

## Operation
- Output dimensions are OH = HEIGHT/2 and OW = WIDTH/2, integer floor. For odd HEIGHT or WIDTH, the last input row or column is ignored.
- fmap_out[r][c][k] = max of fmap_in[2r][2c][k], fmap_in[2r][2c+1][k], fmap_in[2r+1][2c][k], fmap_in[2r+1][2c+1][k].
- Comparison is signed, DATA_W bits. This stays correct if upstream ever passes negative values. The result is one of the four inputs unchanged, with no rounding and no width growth.
- Ties may select any operand, since the values are equal.
- FSM states and transitions:
  - IDLE: if start=1, clear row counter r and column counter c, then go to POOL. Otherwise stay in IDLE.
  - POOL: each cycle, write all CHANNELS of fmap_out[r][c].
    - If c < OW-1, increment c.
    - If c = OW-1 and r < OH-1, set c to 0 and increment r.
    - If r = OH-1 and c = OW-1, go to DONE.
  - DONE: done=1 for this single cycle, then go to IDLE.
  - Any undefined state goes to IDLE.
- In POOL and DONE, start is ignored; no queuing. start asserted on the first cycle back in IDLE is accepted.
- Output pixels not yet written in the current pass keep their value from the previous pass. The consumer reads fmap_out only after done.
- Reset values (rst_n=0, asynchronous):
  - state = IDLE, r = c = 0
  - busy = 0, done = 0
  - every fmap_out element = 0
- Reset asserted mid-pass aborts the pass immediately. All reset values apply and no done pulse is generated. After rst_n deasserts, the block waits for a new start.

## Timing
- Let cycle 0 be the edge at which start is sampled in IDLE.
- Edges 1..OH*OW write pixels in raster order: row-major, c fastest.
- The pixel for (r,c) is written at edge 1 + r*OW + c.
- done is high during the cycle following edge OH*OW, i.e. state DONE. With defaults, the last write is at edge 196 and done is visible after edge 196, sampled at edge 197.
- IDLE is re-entered after edge 197. Minimum start-to-start interval is 198 cycles.
- busy rises after edge 0 and falls after the DONE cycle, together with done falling.
- All fmap_out updates are registered. No combinational path exists from start to any output.

## Structure
- Shared package cnn_pkg holds:
  - DATA_W = 18 localparam
  - state typedef state_t {IDLE, POOL, DONE}
  - a pooled-dimension helper function (floor divide by 2)
- Sub-module pool_max4: purely combinational signed max of four DATA_W operands. It is instantiated CHANNELS times, fed by a column/row mux selected by (r,c).
- The top holds the FSM, counters and output registers.

## Test plan
- Each input 2x2 window holds distinct values with its max at a different corner per window, one fixed pattern per channel. Required response: every fmap_out element equals its window max; done pulses exactly once, sampled at edge 197.
- All inputs = 18'h0 except fmap_in[27][27][15] = 18'h1FFFF. Required response: fmap_out[13][13][15] = 18'h1FFFF and all other outputs = 0.
- Signed check: window {18'h3FFFF (-1), 18'h20000 (most negative), 5, 0}. Required response: output = 5. Window of all negatives {-1, -2, -3, -4}: output = 18'h3FFFF.
- start held high continuously. Required response: passes begin at edges 0 and 198, done is 1 for exactly one cycle per pass, and busy is low only in the IDLE cycles.
- rst_n pulled low at edge 100 of a pass. Required response: immediately fmap_out = 0, busy = 0, done = 0, with no done pulse. A new start then completes a full pass with correct data.
- HEIGHT=5, WIDTH=7 instance. Required response: 2x3 outputs, row 4 and column 6 ignored, done after 6 writes.
